// File: rtl/pll_phase_stepper.sv
// ---------------------------------------------------------------------------
// pll_phase_stepper
//
// Sequencer for the EHXPLLL dynamic phase-shift pins. A request of the form
// "shift output SEL by COUNT steps in direction DIR" is taken over a
// valid/ready handshake. The block then emits COUNT PHASESTEP pulses with
// fixed setup, pulse and gap spacing, and flags completion with a one-cycle
// done pulse. It lives entirely in the PLL reference-clock domain.
//
// Optional feature macro: PLL_PHASE_TRACK_EN
//   defined   : four 8-bit wrapping phase-position counters, one per output,
//               readable through pos_sel/pos_out.
//   undefined : no counters are built, pos_out is constant 8'h00 and pos_sel
//               is ignored.
//
// Parameters
//   SETUP_CYC  cycles PHASESEL/PHASEDIR are stable before the first rise (>=1)
//   PULSE_CYC  PHASESTEP high time per step, in cycles (>=1)
//   GAP_CYC    PHASESTEP low time after each step, in cycles (>=1)
//   CNT_W      width of the step count
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  request can be taken (IDLE and rst low), combinational
//   req_sel    target output: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP
//   req_dir    0 = lag (delay), 1 = lead (advance)
//   req_count  number of steps, 0 allowed
//   busy       high in any state other than IDLE (registered)
//   done       one-cycle pulse when a request finishes (registered)
//   phasesel   to PLL PHASESEL[1:0] (registered)
//   phasedir   to PLL PHASEDIR (registered)
//   phasestep  to PLL PHASESTEP (registered)
//   pos_sel    selects which output's position appears on pos_out
//   pos_out    tracked phase position of output pos_sel (combinational mux)
//   dbg_state  current sequencer state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_sel/req_dir/req_count are sampled only at
// that edge; the requester may change or drop them at any other time.
// req_valid is not required to stay high once the transfer has happened.
// ---------------------------------------------------------------------------
module pll_phase_stepper #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    input  logic [1:0]       pos_sel,
    output logic [7:0]       pos_out,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // The shared cycle counter is sized for the longest of the three phases.
    localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int MAX_CYC = (SETUP_CYC > MAX_PG) ? SETUP_CYC : MAX_PG;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    logic [1:0]       r_state;
    logic [CYC_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_phasesel;
    logic             r_phasedir;
    logic             r_phasestep;

    logic             w_accept;
    logic             w_cnt_zero;

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_cnt_zero = (r_cnt == '0);

    assign busy      = r_busy;
    assign done      = r_done;
    assign phasesel  = r_phasesel;
    assign phasedir  = r_phasedir;
    assign phasestep = r_phasestep;
    assign dbg_state = r_state;

    // Each phase loads r_cnt with its length minus one and leaves when it
    // reaches zero, so a phase of L cycles spans exactly L clock edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_phasesel  <= 2'b00;
            r_phasedir  <= 1'b0;
            r_phasestep <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_phasesel  <= req_sel;
                        r_phasedir  <= req_dir;
                        r_remaining <= req_count;
                        r_cnt       <= CYC_W'(SETUP_CYC - 1);
                        if (req_count == '0) begin
                            // Nothing to step: finish straight from IDLE.
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_SETUP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_PULSE;
                        r_phasestep <= 1'b1;
                        r_cnt       <= CYC_W'(PULSE_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - CYC_W'(1);
                    end
                end
                S_PULSE: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_GAP;
                        r_phasestep <= 1'b0;
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_cnt       <= CYC_W'(GAP_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - CYC_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        // r_remaining was already decremented on PULSE exit.
                        if (r_remaining != '0) begin
                            r_state     <= S_PULSE;
                            r_phasestep <= 1'b1;
                            r_cnt       <= CYC_W'(PULSE_CYC - 1);
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CYC_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_phasestep <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_PHASE_TRACK_EN
    logic [7:0] r_pos [4];
    logic       w_step_done;

    // A step is counted when its pulse ends, i.e. on the PULSE->GAP edge.
    assign w_step_done = (r_state == S_PULSE) && w_cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_pos[i] <= 8'h00;
            end
        end else if (w_step_done) begin
            if (r_phasedir) begin
                r_pos[r_phasesel] <= r_pos[r_phasesel] + 8'd1;
            end else begin
                r_pos[r_phasesel] <= r_pos[r_phasesel] - 8'd1;
            end
        end
    end

    assign pos_out = r_pos[pos_sel];
`else
    logic w_unused_pos_sel;

    assign w_unused_pos_sel = ^pos_sel;
    assign pos_out          = 8'h00;
`endif

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Self-checking bench for pll_phase_stepper. Expected waveforms are derived
// from the documented timing rules: for a request accepted at edge E0 with
// N steps, phasestep is high at offsets S + k*(P+G) .. +P-1, busy covers the
// first S + N*(P+G) cycles and done follows immediately after.
module tb_pll_phase_stepper;

  localparam int S = 2;
  localparam int P = 4;
  localparam int G = 4;
  localparam int CW = 8;
`ifdef PLL_PHASE_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_sel;
  logic          req_dir;
  logic [CW-1:0] req_count;
  logic          busy;
  logic          done;
  logic [1:0]    phasesel;
  logic          phasedir;
  logic          phasestep;
  logic [1:0]    pos_sel;
  logic [7:0]    pos_out;
  logic [1:0]    dbg_state;

  pll_phase_stepper #(
    .SETUP_CYC(S),
    .PULSE_CYC(P),
    .GAP_CYC  (G),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel  (req_sel),
    .req_dir  (req_dir),
    .req_count(req_count),
    .busy     (busy),
    .done     (done),
    .phasesel (phasesel),
    .phasedir (phasedir),
    .phasestep(phasestep),
    .pos_sel  (pos_sel),
    .pos_out  (pos_out),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int pos_model [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap256(input int v);
    return ((v % 256) + 256) % 256;
  endfunction

  function automatic int exp_pos(input int sel);
    return TRACK ? pos_model[sel] : 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles: nothing in flight, so outputs must sit at rest.
  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      pos_sel = 2'($urandom_range(0, 3));
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_phasestep", phasestep, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_pos", pos_out, exp_pos(pos_sel));
    end
  endtask

  // Presents a request in the current cycle, lets it be accepted, then checks
  // every cycle up to and including the done cycle. Returns in the done cycle
  // so the caller may present a back-to-back request.
  task automatic run_req(input logic [1:0] sel, input logic dir, input int n);
    int t_end;
    int period;
    int base;
    int completed;
    int e_ps;
    int e_pos;
    period = P + G;
    t_end = (n == 0) ? 0 : S + n * period;
    base = pos_model[sel];
    req_sel = sel;
    req_dir = dir;
    req_count = CW'(n);
    req_valid = 1'b1;
    #1;
    chk("accept_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    for (int t = 0; t <= t_end; t++) begin
      pos_sel = 2'($urandom_range(0, 3));
      #1;
      e_ps = (n > 0 && t >= S && ((t - S) / period) < n && ((t - S) % period) < P) ? 1 : 0;
      if (t < S + P) completed = 0;
      else begin
        completed = (t - S - P) / period + 1;
        if (completed > n) completed = n;
      end
      chk($sformatf("phasestep@t%0d", t), phasestep, e_ps);
      chk($sformatf("busy@t%0d", t), busy, (t < t_end) ? 1 : 0);
      chk($sformatf("done@t%0d", t), done, (t == t_end) ? 1 : 0);
      chk($sformatf("ready@t%0d", t), req_ready, (t >= t_end) ? 1 : 0);
      chk($sformatf("phasesel@t%0d", t), phasesel, sel);
      chk($sformatf("phasedir@t%0d", t), phasedir, dir);
      if (pos_sel == sel)
        e_pos = TRACK ? wrap256(base + (dir ? completed : -completed)) : 0;
      else
        e_pos = exp_pos(pos_sel);
      chk($sformatf("pos@t%0d", t), pos_out, e_pos);
      if (t < t_end) begin
        // Junk on the request inputs while busy must be ignored.
        req_sel = 2'($urandom_range(0, 3));
        req_dir = 1'($urandom_range(0, 1));
        req_count = CW'($urandom_range(0, 255));
        step();
      end
    end
    pos_model[sel] = wrap256(base + (dir ? n : -n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) pos_model[i] = 0;
    rst = 1'b1;
    req_valid = 1'b1;
    req_sel = 2'b11;
    req_dir = 1'b1;
    req_count = 8'd5;
    pos_sel = 2'b00;

    // Reset held 3 cycles with a pending request: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", req_ready, 0);
      chk("rst_phasestep", phasestep, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_phasesel", phasesel, 0);
      chk("rst_phasedir", phasedir, 0);
      chk("rst_pos", pos_out, 0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);
    idle(2);

    // Directed: sel=01, lead, 3 steps.
    run_req(2'b01, 1'b1, 3);
    idle(2);
    // Zero-count request.
    run_req(2'b10, 1'b1, 0);
    idle(2);
    // Wrap down then back up on CLKOP.
    run_req(2'b11, 1'b0, 1);
    idle(1);
    pos_sel = 2'b11;
    #1;
    chk("wrap_down", pos_out, TRACK ? 255 : 0);
    run_req(2'b11, 1'b1, 2);
    idle(1);
    pos_sel = 2'b11;
    #1;
    chk("wrap_up", pos_out, TRACK ? 1 : 0);

    // Back-to-back requests, each presented in the previous done cycle.
    run_req(2'b10, 1'b0, 2);
    run_req(2'b00, 1'b1, 1);
    run_req(2'b01, 1'b0, 0);
    run_req(2'b11, 1'b0, 1);
    idle(2);

    // Randomized requests, sometimes chained.
    for (int i = 0; i < 8; i++) begin
      run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    // Maximum count must complete without overflow.
    run_req(2'($urandom_range(0, 3)), 1'b1, 255);
    idle(2);

    // Reset during the second pulse of a 5-step request.
    req_sel = 2'b10;
    req_dir = 1'b1;
    req_count = 8'd5;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < S + P + G + 1; i++) step();
    chk("mid_phasestep_high", phasestep, 1);
    rst = 1'b1;
    step();
    chk("abort_phasestep", phasestep, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_phasesel", phasesel, 0);
    rst = 1'b0;
    #1;
    chk("abort_idle_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) pos_model[i] = 0;
    for (int i = 0; i < 4; i++) begin
      pos_sel = 2'(i);
      #1;
      chk($sformatf("abort_pos%0d", i), pos_out, 0);
    end
    idle(4);
    run_req(2'b01, 1'b0, 2);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_phase_stepper.md
# pll_phase_stepper

Sequencer that drives the EHXPLLL dynamic phase-shift pins (PHASESEL, PHASEDIR, PHASESTEP) on behalf of SoC logic. It accepts a request of the form "shift output X by N steps in direction D" over a valid/ready handshake. It then generates a glitch-free PHASESTEP pulse train with guaranteed setup, pulse and gap spacing, and reports completion. It sits in the PLL's reference-clock domain, between the SoC control registers and the PLL primitive.

## Interface
- SETUP_CYC, 2: cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP rise (≥1)
- PULSE_CYC, 4: PHASESTEP high time per step, in cycles (≥1)
- GAP_CYC, 4: PHASESTEP low time after each step, in cycles (≥1)
- CNT_W, 8: width of step count

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request (high only in IDLE and rst low)
- req_sel  in  2  target output: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP
- req_dir  in  1  0 = lag (delay), 1 = lead (advance)
- req_count  in  CNT_W  number of steps, 0 allowed
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a request finishes
- phasesel  out  2  to PLL PHASESEL[1:0]
- phasedir  out  1  to PLL PHASEDIR
- phasestep  out  1  to PLL PHASESTEP, registered
- pos_sel  in  2  selects which output's position is read
- pos_out  out  8  tracked phase position of output pos_sel

## Operation
- States: IDLE, SETUP, PULSE, GAP. One shared cycle counter and one remaining-step counter.
- IDLE: req_ready=1. When req_valid&&req_ready at an edge:
  - latch req_sel → phasesel and req_dir → phasedir;
  - load remaining = req_count;
  - go to SETUP, or stay IDLE with done=1 next cycle if req_count==0.
- SETUP: hold for SETUP_CYC cycles, then go to PULSE.
- PULSE: phasestep=1 for PULSE_CYC cycles. At exit, decrement remaining and go to GAP.
- GAP: phasestep=0 for GAP_CYC cycles. At exit, go to PULSE if remaining≠0. Otherwise go to IDLE with done=1 for that first IDLE cycle.
- phasesel/phasedir change only on acceptance. They hold their value through GAP and IDLE, so the PLL never sees select/direction move while PHASESTEP is high or within SETUP_CYC of its rise.
- req_sel/req_dir/req_count are sampled only on acceptance. Changes while busy are ignored.
- A request accepted in the same cycle done is high is legal. done still pulses exactly once for the finished request.
- Reset values: phasesel=2'b00, phasedir=0, phasestep=0, busy=0, done=0, req_ready=0 while rst=1, state=IDLE, all position counters 0.
- Reset mid-operation: at the next edge phasestep=0 and state=IDLE. No done is issued and the aborted request is discarded.

## Timing
- Accept at edge E0. phasestep first rises at edge E0+SETUP_CYC.
- For N>0 steps: phasestep is high edges E0+SETUP_CYC+k·(PULSE_CYC+GAP_CYC) … +PULSE_CYC−1, for k=0..N−1.
- done is high during the cycle after edge E0+SETUP_CYC+N·(PULSE_CYC+GAP_CYC).
- Total busy length = SETUP_CYC+N·(PULSE_CYC+GAP_CYC) cycles. With defaults, N=1 gives 10 cycles.
- For N=0: done is high in the cycle after E0, and busy never asserts.
- All outputs except req_ready and pos_out are registered. pos_out is a combinational mux of registered counters.
- req_count=2^CNT_W−1 must complete without counter overflow.

## Configuration
- PLL_PHASE_TRACK_EN defined:
  - four 8-bit position counters, one per output;
  - at each PULSE→GAP transition, pos[phasesel] increments if phasedir=1, decrements if phasedir=0;
  - counters wrap modulo 256 (255+1→0, 0−1→255);
  - pos_out = pos[pos_sel];
  - counters clear on rst.
- PLL_PHASE_TRACK_EN undefined:
  - no counters are built;
  - pos_out is constant 8'h00;
  - pos_sel is ignored;
  - all other behaviour is identical.

## Test plan
- Reset held 3 cycles with req_valid=1 → req_ready=0, phasestep=0, no acceptance. After release, req_ready=1.
- Request sel=01, dir=1, count=3 (defaults) → phasesel=01 and phasedir=1 from E0+1. Three 4-cycle phasestep pulses start at E0+2, E0+10, E0+18. done high at E0+26 only. With tracking, pos_out(sel=01)=3.
- Request count=0 → no phasestep activity, busy stays 0, done pulses one cycle after acceptance.
- Tracking: sel=11, dir=0, count=1 from reset → pos_out(sel=11)=255. Then dir=1, count=2 → pos_out=1 (wrap both ways).
- rst asserted during the second PULSE of a count=5 request → phasestep low next edge, no done, state IDLE. pos_out=0 when tracking.
- req_sel/req_dir toggled every cycle while busy → phasesel/phasedir constant until next acceptance. Back-to-back request in the done cycle is accepted and runs fully.
